// File: rtl/project_pwm_peripheral_deadband.sv
// Dead-band generator: delays each rising and falling edge of a raw PWM input by a
// programmable number of cycles and removes pulses or gaps shorter than that delay.
module project_pwm_peripheral_deadband (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_pwm,
    input  logic [3:0] i_red,
    input  logic [3:0] i_fed,
    output logic       o_pwm
);

    typedef enum logic [1:0] {
        StLow,
        StRed,
        StHigh,
        StFed
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pwm_q, pwm_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StLow: begin
                if (i_pwm) begin
                    if (i_red == 4'd0) begin
                        state_d = StHigh;
                    end else begin
                        state_d = StRed;
                        cnt_d   = i_red;
                    end
                end
            end
            StRed: begin
                // Input dropping before the count expires swallows the whole pulse.
                if (!i_pwm) begin
                    state_d = StLow;
                end else if (cnt_q == 4'd1) begin
                    state_d = StHigh;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHigh: begin
                if (!i_pwm) begin
                    if (i_fed == 4'd0) begin
                        state_d = StLow;
                    end else begin
                        state_d = StFed;
                        cnt_d   = i_fed;
                    end
                end
            end
            StFed: begin
                if (i_pwm) begin
                    state_d = StHigh;
                end else if (cnt_q == 4'd1) begin
                    state_d = StLow;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StLow;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output register tracks the next state so o_pwm changes on the same edge as the FSM.
    always_comb begin
        pwm_d = (state_d == StHigh) || (state_d == StFed);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StLow;
            cnt_q   <= 4'd0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_d;
        end
    end

    assign o_pwm = pwm_q;

endmodule

// File: tb/tb_project_pwm_peripheral_deadband.sv
// Scoreboard bench: a run-length reference model predicts o_pwm per edge; a monitor
// compares the DUT one step after each rising edge.
module tb_project_pwm_peripheral_deadband;

    logic       clk;
    logic       rst;
    logic       pwm_in;
    logic [3:0] red;
    logic [3:0] fed;
    logic       pwm_out;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cycle    = 0;

    bit exp_q[$];

    // Reference model state: current input run and the delay latched when it began.
    bit          m_out   = 1'b0;
    bit          m_prev  = 1'b0;
    bit          m_fresh = 1'b1;
    int unsigned m_run   = 0;
    int unsigned m_delay = 0;

    // High-time measurement over a window of cycles.
    bit          meas_on  = 1'b0;
    int unsigned meas_one = 0;

    project_pwm_peripheral_deadband dut (
        .i_clk  (clk),
        .i_reset(rst),
        .i_pwm  (pwm_in),
        .i_red  (red),
        .i_fed  (fed),
        .o_pwm  (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output moves to the new input level once that level has been seen on
    // (delay + 1) consecutive edges, delay being taken at the first edge of the run.
    function automatic bit model_step(input bit p, input int unsigned r, input int unsigned f,
                                      input bit rs);
        if (rs) begin
            m_out   = 1'b0;
            m_fresh = 1'b1;
            return m_out;
        end
        if (m_fresh || (p != m_prev)) begin
            m_run   = 1;
            m_delay = p ? r : f;
            m_fresh = 1'b0;
        end else if (m_run < 1000) begin
            m_run++;
        end
        m_prev = p;
        if ((p != m_out) && (m_run == m_delay + 1)) m_out = p;
        return m_out;
    endfunction

    task automatic drive(input bit p, input int unsigned r, input int unsigned f, input bit rs);
        @(negedge clk);
        if (meas_on && pwm_out === 1'b1) meas_one++;
        pwm_in = p;
        red    = r[3:0];
        fed    = f[3:0];
        rst    = rs;
        exp_q.push_back(model_step(p, r, f, rs));
    endtask

    task automatic hold(input bit p, input int unsigned n, input int unsigned r,
                        input int unsigned f);
        for (int i = 0; i < n; i++) drive(p, r, f, 1'b0);
    endtask

    task automatic check_val(input string name, input int unsigned got, input int unsigned want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Square wave 32/32; high time measured over the third full period.
    task automatic square(input string name, input int unsigned r, input int unsigned f,
                          input int unsigned want_high);
        hold(1'b0, 20, r, f);
        for (int per = 0; per < 3; per++) begin
            if (per == 2) begin
                meas_on  = 1'b1;
                meas_one = 0;
            end
            hold(1'b1, 32, r, f);
            hold(1'b0, 32, r, f);
        end
        meas_on = 1'b0;
        check_val(name, meas_one, want_high);
    endtask

    // Monitor: compare the DUT against the scoreboard after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                bit e;
                e = exp_q.pop_front();
                n_checks++;
                if (pwm_out !== e) begin
                    n_errors++;
                    $display("FAIL o_pwm cycle %0d: got %b expected %b", cycle, pwm_out, e);
                end
            end
        end
    end

    initial begin
        pwm_in = 1'b0;
        red    = 4'd0;
        fed    = 4'd0;
        rst    = 1'b1;

        // Reset held with toggling input, then release with input low.
        for (int i = 0; i < 4; i++) drive(i[0], 0, 0, 1'b1);
        hold(1'b0, 6, 0, 0);

        square("high_red0_fed0", 0, 0, 32);
        square("high_red8_fed0", 8, 0, 24);
        square("high_red0_fed8", 0, 8, 40);
        square("high_red8_fed8", 8, 8, 32);
        square("high_red15_fed15", 15, 15, 32);
        square("high_red1_fed1", 1, 1, 32);

        // Short pulse suppressed by rising delay.
        hold(1'b0, 20, 8, 8);
        meas_on  = 1'b1;
        meas_one = 0;
        hold(1'b1, 5, 8, 8);
        hold(1'b0, 20, 8, 8);
        meas_on = 1'b0;
        check_val("short_pulse_suppressed", meas_one, 0);

        // Pulse exactly equal to the delay is still removed.
        meas_on  = 1'b1;
        meas_one = 0;
        hold(1'b1, 8, 8, 8);
        hold(1'b0, 20, 8, 8);
        meas_on = 1'b0;
        check_val("pulse_eq_delay_suppressed", meas_one, 0);

        // Short gap suppressed by falling delay.
        hold(1'b1, 40, 0, 8);
        meas_on  = 1'b1;
        meas_one = 0;
        hold(1'b0, 3, 0, 8);
        hold(1'b1, 20, 0, 8);
        meas_on = 1'b0;
        check_val("short_gap_suppressed", meas_one, 23);

        // Delay inputs change mid-count; the latched value must hold.
        hold(1'b0, 20, 0, 0);
        drive(1'b1, 6, 0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 15 - i, 0, 1'b0);
        hold(1'b0, 10, 0, 0);

        // Reset in the middle of a rising count, input kept high.
        drive(1'b1, 8, 0, 1'b0);
        hold(1'b1, 3, 8, 0);
        drive(1'b1, 8, 0, 1'b1);
        drive(1'b1, 8, 0, 1'b1);
        hold(1'b1, 12, 8, 0);
        hold(1'b0, 10, 8, 0);

        // Randomized runs with occasional delay changes and resets.
        for (int seg = 0; seg < 300; seg++) begin
            bit          lvl;
            int unsigned len;
            int unsigned r;
            int unsigned f;
            lvl = seg[0];
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 10);
            r   = $urandom_range(0, 15);
            f   = $urandom_range(0, 15);
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 3);
                f = $urandom_range(0, 3);
            end
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) r = $urandom_range(0, 15);
                if ($urandom_range(0, 7) == 0) f = $urandom_range(0, 15);
                drive(lvl, r, f, ($urandom_range(0, 199) == 0));
            end
        end

        @(posedge clk);
        @(posedge clk);
        #2;
        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/project_pwm_peripheral_deadband.md
PROJECT_PWM_PERIPHERAL_DEADBAND -- requirements
Module: project_pwm_peripheral_deadband

Interface
REQ-001 The module SHALL have no parameters; all widths below are fixed.
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-003 i_clk  input  1  rising-edge clock; all state updates occur on this edge.
REQ-004 i_reset  input  1  synchronous active-high reset.
REQ-005 i_pwm  input  1  raw PWM input, synchronous to i_clk.
REQ-006 i_red  input  4  rising-edge delay in clock cycles (0-15).
REQ-007 i_fed  input  4  falling-edge delay in clock cycles (0-15).
REQ-008 o_pwm  output  1  dead-band-adjusted PWM, driven directly from a register.

Function
REQ-009 The block SHALL be a four-state FSM:
- S_LOW: o_pwm=0.
- S_RED: rising delay counting, o_pwm=0.
- S_HIGH: o_pwm=1.
- S_FED: falling delay counting, o_pwm=1.
REQ-010 The block SHALL have a 4-bit down-counter cnt.
REQ-011 o_pwm SHALL be 1 exactly when the state is S_HIGH or S_FED, with no combinational path from any input to o_pwm.
REQ-012 S_LOW transitions:
- i_pwm=0 -> stay in S_LOW.
- i_pwm=1 and i_red=0 -> S_HIGH.
- i_pwm=1 and i_red!=0 -> S_RED with cnt<=i_red.
REQ-013 S_RED transitions:
- i_pwm=0 -> S_LOW (pulse suppressed).
- else cnt==1 -> S_HIGH.
- else cnt<=cnt-1.
REQ-014 S_HIGH transitions:
- i_pwm=1 -> stay in S_HIGH.
- i_pwm=0 and i_fed=0 -> S_LOW.
- i_pwm=0 and i_fed!=0 -> S_FED with cnt<=i_fed.
REQ-015 S_FED transitions:
- i_pwm=1 -> S_HIGH (low gap suppressed).
- else cnt==1 -> S_LOW.
- else cnt<=cnt-1.
REQ-016 Resulting latency, where edge k is the first edge sampling the new i_pwm level:
- With delay 0, o_pwm SHALL follow i_pwm one cycle late (updated at edge k).
- With delay N, o_pwm SHALL change at edge k+N.
REQ-017 i_red and i_fed SHALL be sampled only on entry to S_RED or S_FED; changes during a count SHALL NOT affect that count.
REQ-018 The counter SHALL never wrap: the maximum delay is 15 cycles and cnt never decrements below 1.
REQ-019 Any input pulse or gap shorter than the active delay SHALL be removed entirely from o_pwm, with no glitch.
REQ-020 If input high time is H cycles and it exceeds i_red, o_pwm high time SHALL be H - i_red + i_fed.

Reset
REQ-021 While i_reset=1 at a clock edge: state<=S_LOW, cnt<=0, o_pwm<=0, regardless of i_pwm, i_red, i_fed or the current state.
REQ-022 Reset SHALL take priority over all transitions, including mid-count in S_RED or S_FED.
REQ-023 After reset deasserts, normal operation SHALL resume from S_LOW on the next edge.

Verification
REQ-024 Reset: hold i_reset=1 for 4 cycles with i_pwm toggling -> o_pwm=0 throughout; after release with i_pwm=0, o_pwm stays 0.
REQ-025 i_red=0, i_fed=0, i_pwm square wave 32 cycles high / 32 cycles low -> o_pwm is the same wave delayed 1 cycle, 32 cycles high.
REQ-026 i_red=8, i_fed=0, same wave -> o_pwm rises 8 cycles after the zero-delay rise and falls with 1-cycle latency; high time 24 cycles.
REQ-027 i_red=0, i_fed=8 -> o_pwm rises with 1-cycle latency and falls 8 cycles late; high time 40 cycles, low time 24 cycles.
REQ-028 i_red=8, i_fed=8 -> o_pwm is the input delayed 9 cycles; high 32, low 32.
REQ-029 Suppression and reset mid-count:
- i_red=8 with a 5-cycle high pulse -> o_pwm stays 0.
- i_fed=8 with a 3-cycle low gap -> o_pwm stays 1.
- i_reset=1 asserted during S_RED -> o_pwm=0 and the count is discarded.
